// File: rtl/radar_point_cloud_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : radar_point_cloud_sequencer
//  Purpose  : Frame controller pairing clutter-free points with Doppler
//             velocities into fused 128-bit beats, with timeout drops and
//             per-frame counting. Optional macro: RPC_SEQ_FRAME_TAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module radar_point_cloud_sequencer #(
    parameter int MAX_PTS     = 1024,
    parameter int CNT_W       = 11,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [127:0]     pt_data,
    input  logic             vel_valid,
    output logic             vel_ready,
    input  logic [15:0]      vel_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic [CNT_W-1:0] pts_in_frame,
    output logic [15:0]      drop_cnt,
    output logic             busy
);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             pt_full_q, pt_full_d, vel_full_q, vel_full_d;
    logic [111:0]     pt_hold_q, pt_hold_d;
    logic [15:0]      vel_hold_q, vel_hold_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [127:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] pts_q, pts_d;
    logic [15:0]      drop_q, drop_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             w_load, w_last_pt, w_lone, w_drop, w_done, w_pt_hs, w_vel_hs;
    logic [127:0]     w_fused;
    logic             unused_bits;

`ifdef RPC_SEQ_FRAME_TAG_EN
    logic [7:0] frame_id_q, frame_id_d;
    assign w_fused     = {frame_id_q, pt_hold_q[103:0], vel_hold_q};
    assign unused_bits = ^{pt_data[15:0], pt_hold_q[111:104]};
    assign frame_id_d  = w_done ? frame_id_q + 8'd1 : frame_id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) frame_id_q <= 8'd0;
        else        frame_id_q <= frame_id_d;
    end
`else
    assign w_fused     = {pt_hold_q, vel_hold_q};
    assign unused_bits = ^pt_data[15:0];
`endif

    always_comb begin
        w_load    = pt_full_q && vel_full_q && (!out_valid_q || out_ready) && (state_q != ST_IDLE);
        w_last_pt = w_load && (state_q == ST_COLLECT) && (pts_q == CNT_W'(MAX_PTS - 1));
        w_lone    = pt_full_q ^ vel_full_q;
        // A hold emptied by this cycle's load may refill at once, except on the frame-closing load.
        pt_ready  = (state_q == ST_COLLECT) && !frame_end && (!pt_full_q  || (w_load && !w_last_pt));
        vel_ready = (state_q == ST_COLLECT) && !frame_end && (!vel_full_q || (w_load && !w_last_pt));
        w_pt_hs   = pt_valid && pt_ready;
        w_vel_hs  = vel_valid && vel_ready;
        w_done    = (state_q == ST_DRAIN) && !out_valid_q && !pt_full_q && !vel_full_q;

        w_drop = 1'b0;
        tmo_d  = '0;
        if (state_q == ST_DRAIN) begin
            w_drop = w_lone;
        end else if ((state_q == ST_COLLECT) && w_lone) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYC - 1))
                w_drop = pt_full_q ? !w_vel_hs : !w_pt_hs;
            else
                tmo_d = tmo_q + TMO_W'(1);
        end

        pt_full_d  = pt_full_q;
        pt_hold_d  = pt_hold_q;
        vel_full_d = vel_full_q;
        vel_hold_d = vel_hold_q;
        if (w_load || (w_drop && pt_full_q))  pt_full_d  = 1'b0;
        if (w_load || (w_drop && vel_full_q)) vel_full_d = 1'b0;
        if (w_pt_hs) begin
            pt_full_d = 1'b1;
            pt_hold_d = pt_data[127:16];
        end
        if (w_vel_hs) begin
            vel_full_d = 1'b1;
            vel_hold_d = vel_data;
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (w_load) begin
            out_valid_d = 1'b1;
            out_data_d  = w_fused;
            out_last_d  = w_last_pt || (state_q == ST_DRAIN) || frame_end;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if ((state_q == ST_COLLECT) && frame_end && out_valid_q &&
                     !(pt_full_q && vel_full_q)) begin
            // Stalled beat becomes the frame's last when no complete pair is left behind it.
            out_last_d = 1'b1;
        end

        pts_d = pts_q;
        if ((state_q == ST_IDLE) && frame_start) pts_d = '0;
        else if (w_load)                         pts_d = pts_q + CNT_W'(1);

        drop_d = (w_drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (frame_start) state_d = ST_COLLECT;
            ST_COLLECT: if (frame_end || w_last_pt) state_d = ST_DRAIN;
            ST_DRAIN:   if (w_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pt_full_q   <= 1'b0;
            vel_full_q  <= 1'b0;
            pt_hold_q   <= '0;
            vel_hold_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            pts_q       <= '0;
            drop_q      <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            pt_full_q   <= pt_full_d;
            vel_full_q  <= vel_full_d;
            pt_hold_q   <= pt_hold_d;
            vel_hold_q  <= vel_hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            pts_q       <= pts_d;
            drop_q      <= drop_d;
            tmo_q       <= tmo_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign frame_done   = w_done;
    assign pts_in_frame = pts_q;
    assign drop_cnt     = drop_q;
    assign busy         = (state_q != ST_IDLE);
endmodule
`default_nettype wire
